fetch_unit: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/fetch_unit_if.sv | 47 ++++
 rtl/fetch_pc_reg.sv | 61 ++++++
 rtl/fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types for the fetch stage. Provides the machine
//               word type, the fetch FSM state encoding, the next-PC select
//               encoding and the sequential PC step.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Byte distance between sequential instructions.
  localparam word_t PC_STEP = 32'd4;

  // Fetch stage control states.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Next-PC source select driven by the fetch FSM.
  typedef enum logic [1:0] {
    PC_HOLD    = 2'd0,
    PC_INC     = 2'd1,
    PC_REDIR   = 2'd2,
    PC_REDIR_Q = 2'd3
  } pc_sel_t;

  // Sequential successor of a PC; wraps naturally modulo 2^32.
  function automatic word_t next_seq_pc(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch stage's bus signals: icache request and
//               response, hazard/redirect/halt controls from later stages,
//               and the IF/ID pipeline latch inputs.
//   master : fetch unit side (drives iREN, iaddr and the IF/ID signals)
//   slave  : environment side (icache, hazard unit, branch resolution)
// Signals :
//   ihit, iload          icache response (iload valid with ihit)
//   iREN, iaddr          icache read request
//   stall                hazard unit holds IF/ID
//   redirect/redirect_pc taken branch/jump/mispredict and its target
//   halt                 halt retired downstream
//   instr/npc/curr_pc    IF/ID data inputs
//   ifid_en/ifid_flush   IF/ID enable and flush
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t instr;
  word_t npc;
  word_t curr_pc;
  logic  ifid_en;
  logic  ifid_flush;

  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output iREN, iaddr, instr, npc, curr_pc, ifid_en, ifid_flush
  );

  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt,
    input  iREN, iaddr, instr, npc, curr_pc, ifid_en, ifid_flush
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : PC register and pending-redirect target register with the
//               next-PC mux. The fetch FSM chooses the source each cycle.
// Ports :
//   clk            clock, rising edge
//   nrst           synchronous active-low reset
//   i_pc_sel       next-PC source (hold / +4 / redirect_pc / saved target)
//   i_redir_load   capture i_redirect_pc into the saved-target register
//   i_redirect_pc  redirect target from later stages
//   o_pc           current PC
//   o_redir_q      saved redirect target
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    nrst,
  input  pc_sel_t i_pc_sel,
  input  logic    i_redir_load,
  input  word_t   i_redirect_pc,
  output word_t   o_pc,
  output word_t   o_redir_q
);

  word_t r_pc;
  word_t r_redir_q;
  word_t w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    case (i_pc_sel)
      PC_HOLD:    w_pc_next = r_pc;
      PC_INC:     w_pc_next = next_seq_pc(r_pc);
      PC_REDIR:   w_pc_next = i_redirect_pc;
      PC_REDIR_Q: w_pc_next = r_redir_q;
      default:    w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_pc      <= PC_INIT;
      r_redir_q <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (i_redir_load) begin
        r_redir_q <= i_redirect_pc;
      end
    end
  end

  assign o_pc      = r_pc;
  assign o_redir_q = r_redir_q;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage, producer side of the IF/ID latch.
//               Owns the PC, issues icache reads, and absorbs redirects,
//               stalls and halt - including redirects that land while an
//               icache miss is still outstanding (SQUASH state).
// Ports :
//   CLK      clock, rising edge
//   nRST     synchronous active-low reset; forces iREN=0, ifid_en=0,
//            ifid_flush=1 while low
//   bus      fetch_unit_if.master (icache, controls, IF/ID inputs)
//   fetch_cnt/miss_cnt/squash_cnt  saturating event counters, present only
//            when FETCH_PERF_CNT_EN is defined
// Build option : FETCH_PERF_CNT_EN - adds the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
`ifdef FETCH_PERF_CNT_EN
  output word_t fetch_cnt,
  output word_t miss_cnt,
  output word_t squash_cnt,
`endif
  fetch_unit_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  pc_sel_t      w_pc_sel;
  logic         w_redir_load;
  word_t        w_pc;
  word_t        w_redir_q;
  logic         w_iren;
  logic         w_ifid_en;
  logic         w_ifid_flush;

  // --------------------------------------------------------------------------
  // PC / saved-target registers
  // --------------------------------------------------------------------------
  fetch_pc_reg #(
    .PC_INIT (PC_INIT)
  ) u_pc_reg (
    .clk           (CLK),
    .nrst          (nRST),
    .i_pc_sel      (w_pc_sel),
    .i_redir_load  (w_redir_load),
    .i_redirect_pc (bus.redirect_pc),
    .o_pc          (w_pc),
    .o_redir_q     (w_redir_q)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and PC control. Priority: halt > redirect > stall > ihit.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pc_sel     = PC_HOLD;
    w_redir_load = 1'b0;
    case (r_state)
      FETCH: begin
        if (bus.halt) begin
          w_state_next = HALTED;
        end else if (bus.redirect && (bus.ihit || !w_iren)) begin
          // The word arriving with the redirect is on the wrong path.
          w_pc_sel = PC_REDIR;
        end else if (bus.redirect) begin
          // Miss outstanding: keep iaddr stable for the cache and park
          // the target until the in-flight read completes.
          w_redir_load = 1'b1;
          w_state_next = SQUASH;
        end else if (bus.ihit && !bus.stall) begin
          w_pc_sel = PC_INC;
        end
      end
      SQUASH: begin
        if (bus.redirect && !bus.halt) begin
          w_redir_load = 1'b1;
        end
        if (bus.halt) begin
          w_state_next = HALTED;
        end else if (bus.ihit) begin
          // A same-cycle redirect is newer than the parked target.
          w_pc_sel     = bus.redirect ? PC_REDIR : PC_REDIR_Q;
          w_state_next = FETCH;
        end
      end
      HALTED: begin
        w_state_next = HALTED;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Reset low overrides every other input.
  // --------------------------------------------------------------------------
  always_comb begin
    w_iren       = 1'b0;
    w_ifid_en    = 1'b0;
    w_ifid_flush = 1'b1;
    if (nRST) begin
      w_iren       = (r_state != HALTED);
      w_ifid_flush = bus.redirect;
      w_ifid_en    = (r_state == FETCH) && bus.ihit && !bus.stall &&
                     !bus.redirect && !bus.halt;
    end
  end

  assign bus.iREN       = w_iren;
  assign bus.iaddr      = w_pc;
  assign bus.curr_pc    = w_pc;
  assign bus.npc        = next_seq_pc(w_pc);
  assign bus.instr      = bus.iload;
  assign bus.ifid_en    = w_ifid_en;
  assign bus.ifid_flush = w_ifid_flush;

`ifdef FETCH_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating event counters
  // --------------------------------------------------------------------------
  word_t r_fetch_cnt;
  word_t r_miss_cnt;
  word_t r_squash_cnt;
  logic  w_miss_evt;
  logic  w_squash_evt;

  assign w_miss_evt   = w_iren && !bus.ihit;
  // Every FETCH-state redirect that is not pre-empted by halt; this covers
  // both the FETCH->SQUASH case and the in-place redirect on a hit.
  assign w_squash_evt = nRST && (r_state == FETCH) && bus.redirect && !bus.halt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_fetch_cnt  <= '0;
      r_miss_cnt   <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (w_ifid_en && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_miss_evt && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
      if (w_squash_evt && (r_squash_cnt != '1)) begin
        r_squash_cnt <= r_squash_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign squash_cnt = r_squash_cnt;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit (PC_INIT=0x100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   nvec;
  int   nerr;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  word_t fetch_cnt;
  word_t miss_cnt;
  word_t squash_cnt;
`endif

  fetch_unit #(
    .PC_INIT (32'h0000_0100)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .miss_cnt   (miss_cnt),
    .squash_cnt (squash_cnt),
`endif
    .bus        (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Move the PC to a known value via a same-cycle redirect + hit in FETCH.
  task automatic goto_pc(input word_t target);
    bus.halt        = 1'b0;
    bus.stall       = 1'b0;
    bus.ihit        = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect    = 1'b0;
    bus.ihit        = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.ihit = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.halt = 1'b0;
    bus.iload = 32'h0; bus.redirect_pc = 32'h0;
    step(); step();
    nvec++; if (bus.iREN !== 1'b0) begin nerr++; $display("FAIL reset_iren: got %b expected 0", bus.iREN); end
    nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL reset_ifid_en: got %b expected 0", bus.ifid_en); end
    nvec++; if (bus.ifid_flush !== 1'b1) begin nerr++; $display("FAIL reset_flush: got %b expected 1", bus.ifid_flush); end
    nvec++; if (bus.iaddr !== 32'h100) begin nerr++; $display("FAIL reset_iaddr: got %h expected 00000100", bus.iaddr); end
    // Redirect during reset must not move the PC.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0BAD;
    step();
    bus.redirect = 1'b0;
    #1;
    nvec++; if (bus.curr_pc !== 32'h100) begin nerr++; $display("FAIL reset_redirect_pc: got %h expected 00000100", bus.curr_pc); end
  endtask

  task automatic test_sequential();
    word_t exp_pc;
    nRST = 1'b1; bus.ihit = 1'b1; bus.stall = 1'b0;
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      bus.iload = 32'hA000_0000 + 32'(i);
      #1;
      nvec++; if (bus.iaddr !== exp_pc) begin nerr++; $display("FAIL seq_iaddr[%0d]: got %h expected %h", i, bus.iaddr, exp_pc); end
      nvec++; if (bus.ifid_en !== 1'b1) begin nerr++; $display("FAIL seq_ifid_en[%0d]: got %b expected 1", i, bus.ifid_en); end
      nvec++; if (bus.npc !== exp_pc + 32'd4) begin nerr++; $display("FAIL seq_npc[%0d]: got %h expected %h", i, bus.npc, exp_pc + 32'd4); end
      nvec++; if (bus.instr !== 32'hA000_0000 + 32'(i)) begin nerr++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, bus.instr, 32'hA000_0000 + 32'(i)); end
      nvec++; if (bus.ifid_flush !== 1'b0) begin nerr++; $display("FAIL seq_flush[%0d]: got %b expected 0", i, bus.ifid_flush); end
      step();
      exp_pc = exp_pc + 32'd4;
    end
    nvec++; if (bus.iaddr !== 32'h10C) begin nerr++; $display("FAIL seq_iaddr_end: got %h expected 0000010c", bus.iaddr); end
  endtask

  task automatic test_miss();
    goto_pc(32'h200);
    bus.ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nvec++; if (bus.iaddr !== 32'h200) begin nerr++; $display("FAIL miss_iaddr[%0d]: got %h expected 00000200", i, bus.iaddr); end
      nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL miss_ifid_en[%0d]: got %b expected 0", i, bus.ifid_en); end
      nvec++; if (bus.iREN !== 1'b1) begin nerr++; $display("FAIL miss_iren[%0d]: got %b expected 1", i, bus.iREN); end
      step();
    end
    bus.ihit = 1'b1;
    #1;
    nvec++; if (bus.ifid_en !== 1'b1) begin nerr++; $display("FAIL miss_hit_en: got %b expected 1", bus.ifid_en); end
    step();
    nvec++; if (bus.iaddr !== 32'h204) begin nerr++; $display("FAIL miss_next_iaddr: got %h expected 00000204", bus.iaddr); end
  endtask

  task automatic test_stall();
    goto_pc(32'h300);
    bus.ihit = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL stall_ifid_en[%0d]: got %b expected 0", i, bus.ifid_en); end
      nvec++; if (bus.iaddr !== 32'h300) begin nerr++; $display("FAIL stall_iaddr[%0d]: got %h expected 00000300", i, bus.iaddr); end
      step();
    end
    bus.stall = 1'b0;
    #1;
    nvec++; if (bus.ifid_en !== 1'b1) begin nerr++; $display("FAIL stall_release_en: got %b expected 1", bus.ifid_en); end
    step();
    nvec++; if (bus.iaddr !== 32'h304) begin nerr++; $display("FAIL stall_next_iaddr: got %h expected 00000304", bus.iaddr); end
  endtask

  task automatic test_squash();
    goto_pc(32'h400);
    // Redirect while the read at 0x400 is still missing.
    bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h800;
    #1;
    nvec++; if (bus.ifid_flush !== 1'b1) begin nerr++; $display("FAIL sq_flush: got %b expected 1", bus.ifid_flush); end
    nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL sq_en0: got %b expected 0", bus.ifid_en); end
    step();
    bus.redirect = 1'b0;
    #1;
    nvec++; if (bus.iaddr !== 32'h400) begin nerr++; $display("FAIL sq_iaddr_held: got %h expected 00000400", bus.iaddr); end
    nvec++; if (bus.iREN !== 1'b1) begin nerr++; $display("FAIL sq_iren: got %b expected 1", bus.iREN); end
    step();
    bus.ihit = 1'b1;
    #1;
    nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL sq_hit_en: got %b expected 0", bus.ifid_en); end
    step();
    nvec++; if (bus.iaddr !== 32'h800) begin nerr++; $display("FAIL sq_target: got %h expected 00000800", bus.iaddr); end
    // Two redirects while squashing: the later one wins.
    bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h900;
    step();
    bus.redirect_pc = 32'hC00;
    step();
    bus.redirect = 1'b0; bus.ihit = 1'b1;
    step();
    nvec++; if (bus.iaddr !== 32'hC00) begin nerr++; $display("FAIL sq_newest: got %h expected 00000c00", bus.iaddr); end
    // Redirect arriving together with the completing hit in SQUASH.
    bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'hD00;
    step();
    bus.redirect_pc = 32'hE00; bus.ihit = 1'b1;
    step();
    bus.redirect = 1'b0; bus.ihit = 1'b0;
    #1;
    nvec++; if (bus.iaddr !== 32'hE00) begin nerr++; $display("FAIL sq_same_cycle: got %h expected 00000e00", bus.iaddr); end
  endtask

  task automatic test_redirect_hit();
    bus.ihit = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'hA00;
    #1;
    nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL rh_en: got %b expected 0", bus.ifid_en); end
    nvec++; if (bus.ifid_flush !== 1'b1) begin nerr++; $display("FAIL rh_flush: got %b expected 1", bus.ifid_flush); end
    step();
    bus.redirect = 1'b0; bus.ihit = 1'b0;
    #1;
    nvec++; if (bus.iaddr !== 32'hA00) begin nerr++; $display("FAIL rh_iaddr: got %h expected 00000a00", bus.iaddr); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    nvec++; if (bus.npc !== 32'h0) begin nerr++; $display("FAIL wrap_npc: got %h expected 00000000", bus.npc); end
    bus.ihit = 1'b1;
    step();
    bus.ihit = 1'b0;
    #1;
    nvec++; if (bus.iaddr !== 32'h0) begin nerr++; $display("FAIL wrap_iaddr: got %h expected 00000000", bus.iaddr); end
  endtask

  task automatic test_halt();
    // Enter SQUASH from pc=0, then halt together with another redirect.
    bus.ihit = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'hB00;
    step();
    bus.halt = 1'b1; bus.redirect_pc = 32'hC00;
    step();
    bus.halt = 1'b0; bus.redirect = 1'b0; bus.ihit = 1'b1;
    #1;
    nvec++; if (bus.iREN !== 1'b0) begin nerr++; $display("FAIL halt_iren: got %b expected 0", bus.iREN); end
    nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL halt_en: got %b expected 0", bus.ifid_en); end
    step();
    nvec++; if (bus.iaddr !== 32'h0) begin nerr++; $display("FAIL halt_frozen: got %h expected 00000000", bus.iaddr); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'hF00;
    #1;
    nvec++; if (bus.ifid_flush !== 1'b1) begin nerr++; $display("FAIL halt_flush: got %b expected 1", bus.ifid_flush); end
    step();
    bus.redirect = 1'b0;
    #1;
    nvec++; if (bus.iaddr !== 32'h0) begin nerr++; $display("FAIL halt_redirect_pc: got %h expected 00000000", bus.iaddr); end
    nvec++; if (bus.ifid_flush !== 1'b0) begin nerr++; $display("FAIL halt_flush_drop: got %b expected 0", bus.ifid_flush); end
    // Reset recovers from HALTED.
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    #1;
    nvec++; if (bus.iaddr !== 32'h100) begin nerr++; $display("FAIL halt_reset_pc: got %h expected 00000100", bus.iaddr); end
    nvec++; if (bus.iREN !== 1'b1) begin nerr++; $display("FAIL halt_reset_iren: got %b expected 1", bus.iREN); end
    step();
    nvec++; if (bus.iaddr !== 32'h104) begin nerr++; $display("FAIL halt_resume: got %h expected 00000104", bus.iaddr); end
    // Halt in FETCH with a hit present: word not taken, PC frozen.
    bus.halt = 1'b1;
    #1;
    nvec++; if (bus.ifid_en !== 1'b0) begin nerr++; $display("FAIL halt_fetch_en: got %b expected 0", bus.ifid_en); end
    step();
    bus.halt = 1'b0;
    step();
    nvec++; if (bus.iaddr !== 32'h104) begin nerr++; $display("FAIL halt_fetch_pc: got %h expected 00000104", bus.iaddr); end
    nvec++; if (bus.iREN !== 1'b0) begin nerr++; $display("FAIL halt_fetch_iren: got %b expected 0", bus.iREN); end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    nRST = 1'b0;
    bus.ihit = 1'b0; bus.iload = 32'h0; bus.stall = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.halt = 1'b0;
    test_reset();
    test_sequential();
    test_miss();
    test_stall();
    test_squash();
    test_redirect_hit();
    test_wrap();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
